// File: rtl/bin2segm_multi.sv
// bin2segm_multi: signed two's-complement value -> DIGITS magnitude displays
// plus one sign display, converted by a sequential double-dabble engine.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros and place
// the minus glyph directly above the most significant shown digit.
module bin2segm_multi #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [WIDTH-1:0]        i_value,
   input  logic                    i_load,
   input  logic                    i_en,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_ovf,
   output logic [7*(DIGITS+1)-1:0] o_display
);

   localparam logic [6:0] SEG_SIGN = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int XW = (WIDTH > 64) ? WIDTH : 64;

   // Largest magnitude the digit row can show; saturates when 10^DIGITS
   // no longer fits in 64 bits (such a row can show any 64-bit value).
   function automatic logic [63:0] max_shown(input int n);
      logic [63:0] p;
      if (n > 19) return '1;
      p = 64'd1;
      for (int k = 0; k < n; k++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

   localparam logic [63:0] MAX_VAL = max_shown(DIGITS);

   // Active-low {g,f,e,d,c,b,a} glyph for one BCD nibble.
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return SEG_OFF;
      endcase
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

   state_t                   state_reg, state_next;
   logic                     load_accept, shift_en, update_en;
   logic                     sign_reg, zero_reg, ovf_cap_reg;
   logic [WIDTH-1:0]         mag_reg;
   logic [BW-1:0]            bcd_reg, bcd_adj;
   logic [CW-1:0]            cnt_reg;
   logic                     busy_reg, done_reg, ovf_reg;
   logic [7*(DIGITS+1)-1:0]  disp_reg, disp_next;
   logic [WIDTH-1:0]         abs_val;
   logic                     ovf_now;

   // Magnitude of the incoming value; the most negative input maps to 2^(WIDTH-1).
   assign abs_val = i_value[WIDTH-1] ? (~i_value + WIDTH'(1)) : i_value;
   assign ovf_now = XW'(abs_val) > XW'(MAX_VAL);

   // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         logic [3:0] nib;
         assign nib = bcd_reg[4*gi +: 4];
         assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   endgenerate

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // FSM next-state logic; SHIFT leaves after the counter's last step.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (i_load) state_next = SHIFT;
         SHIFT:   if (cnt_reg == CW'(1)) state_next = UPDATE;
         UPDATE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM output decode driving the datapath enables.
   always_comb begin
      load_accept = (state_reg == IDLE) && i_load;
      shift_en    = (state_reg == SHIFT);
      update_en   = (state_reg == UPDATE);
   end

   // Display image built from the finished BCD word during UPDATE.
   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      int msd;
      msd = 0;
`endif
      disp_next = {(DIGITS+1){SEG_OFF}};
      if (ovf_cap_reg) begin
         disp_next = {(DIGITS+1){SEG_SIGN}};
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
         for (int d = 0; d < DIGITS; d++)
            if (bcd_reg[4*d +: 4] != 4'd0) msd = d;
         for (int d = 0; d < DIGITS; d++)
            if (d <= msd) disp_next[7*d +: 7] = seg_of(bcd_reg[4*d +: 4]);
         if (sign_reg && !zero_reg) disp_next[7*(msd+1) +: 7] = SEG_SIGN;
`else
         for (int d = 0; d < DIGITS; d++)
            disp_next[7*d +: 7] = seg_of(bcd_reg[4*d +: 4]);
         if (sign_reg && !zero_reg) disp_next[7*DIGITS +: 7] = SEG_SIGN;
`endif
      end
   end

   // Datapath: capture on load, shift during SHIFT, publish results on UPDATE.
   // Busy stays high through the done cycle so a new load lands on the
   // edge right after o_done.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sign_reg    <= 1'b0;
         zero_reg    <= 1'b0;
         ovf_cap_reg <= 1'b0;
         mag_reg     <= '0;
         bcd_reg     <= '0;
         cnt_reg     <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
         disp_reg    <= {(DIGITS+1){SEG_OFF}};
      end else begin
         busy_reg <= (state_reg != IDLE) || (state_next != IDLE);
         done_reg <= update_en;
         if (load_accept) begin
            sign_reg    <= i_value[WIDTH-1];
            zero_reg    <= (abs_val == '0);
            ovf_cap_reg <= ovf_now;
            mag_reg     <= abs_val;
            bcd_reg     <= '0;
            cnt_reg     <= CW'(WIDTH);
         end else if (shift_en) begin
            {bcd_reg, mag_reg} <= {bcd_adj, mag_reg} << 1;
            cnt_reg            <= cnt_reg - CW'(1);
         end
         if (update_en) begin
            disp_reg <= disp_next;
            ovf_reg  <= ovf_cap_reg;
         end
      end
   end

   assign o_busy    = busy_reg;
   assign o_done    = done_reg;
   assign o_ovf     = ovf_reg;
   assign o_display = i_en ? disp_reg : {(DIGITS+1){SEG_OFF}};

endmodule
